// File: rtl/alu_seq_pkg.sv
// Shared types and constants for the alu_seq accumulator datapath:
// the control state encoding, the ALU select encodings and the data width.
package alu_seq_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        RESP = 2'b10
    } state_t;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,   // A + B
        OP_SUB  = 3'b001,   // A - B
        OP_INC  = 3'b010,   // A + 1
        OP_PASS = 3'b011,   // A
        OP_AND  = 3'b100,   // A & B
        OP_OR   = 3'b101,   // A | B
        OP_XOR  = 3'b110,   // A ^ B
        OP_NOT  = 3'b111    // ~A
    } alu_op_t;

endpackage

// File: rtl/alu_seq_alu_4bit.sv
// alu_4bit: purely combinational 4-bit ALU used by alu_seq.
// Build option ALU_SEQ_COUT_EN: when defined, the add/sub/inc paths are
// widened by one bit and o_cout reports carry (add/inc) or borrow (sub).
// When undefined, o_cout is a constant 0 and only 4-bit arithmetic exists.
module alu_4bit
    import alu_seq_pkg::*;
(
    input  logic [DATA_W-1:0] i_a,
    input  logic [DATA_W-1:0] i_b,
    input  alu_op_t           i_op,
    output logic [DATA_W-1:0] o_y,
    output logic              o_cout
);

`ifdef ALU_SEQ_COUT_EN
    logic [DATA_W:0] w_sum;
    logic [DATA_W:0] w_diff;
    logic [DATA_W:0] w_inc;

    // Zero-extended operands so bit DATA_W captures carry, or borrow on A < B.
    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_inc  = {1'b0, i_a} + {{DATA_W{1'b0}}, 1'b1};

    // Select result and carry; logic ops never produce a carry.
    always_comb begin
        o_y    = i_a;
        o_cout = 1'b0;
        case (i_op)
            OP_ADD:  begin o_y = w_sum[DATA_W-1:0];  o_cout = w_sum[DATA_W];  end
            OP_SUB:  begin o_y = w_diff[DATA_W-1:0]; o_cout = w_diff[DATA_W]; end
            OP_INC:  begin o_y = w_inc[DATA_W-1:0];  o_cout = w_inc[DATA_W];  end
            OP_PASS: o_y = i_a;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NOT:  o_y = ~i_a;
            default: o_y = i_a;
        endcase
    end
`else
    // Select result; arithmetic wraps modulo 2**DATA_W.
    always_comb begin
        o_y = i_a;
        case (i_op)
            OP_ADD:  o_y = i_a + i_b;
            OP_SUB:  o_y = i_a - i_b;
            OP_INC:  o_y = i_a + {{(DATA_W-1){1'b0}}, 1'b1};
            OP_PASS: o_y = i_a;
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            OP_NOT:  o_y = ~i_a;
            default: o_y = i_a;
        endcase
    end

    assign o_cout = 1'b0;
`endif

endmodule

// File: rtl/alu_seq.sv
// alu_seq: single-command accumulator ALU with valid/ready handshakes.
// IDLE accepts a command, EXEC updates the accumulator and result
// registers, RESP holds the result until the consumer takes it.
// Build option ALU_SEQ_COUT_EN (inside alu_4bit) enables the carry/borrow
// output; without it out_cout stays 0 and the port list is unchanged.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_ACC = 4'h0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_load,
    input  logic [2:0]        in_op,
    input  logic [DATA_W-1:0] in_operand,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_result,
    output logic              out_zero,
    output logic              out_cout
);

    state_t            r_state;
    logic              r_in_ready;
    logic              r_load;
    alu_op_t           r_op;
    logic [DATA_W-1:0] r_operand;
    logic [DATA_W-1:0] r_acc;
    logic [DATA_W-1:0] r_out_result;
    logic              r_out_zero;
    logic              r_out_cout;
    logic              r_out_valid;

    logic [DATA_W-1:0] w_alu_y;
    logic              w_alu_cout;
    logic [DATA_W-1:0] w_new_acc;

    alu_4bit u_alu (
        .i_a    (r_acc),
        .i_b    (r_operand),
        .i_op   (r_op),
        .o_y    (w_alu_y),
        .o_cout (w_alu_cout)
    );

    // A load replaces the accumulator; every other command takes the ALU output.
    assign w_new_acc = r_load ? r_operand : w_alu_y;

    // Control FSM with registered handshake and result outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= IDLE;
            r_in_ready   <= 1'b1;
            r_load       <= 1'b0;
            r_op         <= OP_ADD;
            r_operand    <= '0;
            r_acc        <= RESET_ACC;
            r_out_result <= '0;
            r_out_zero   <= 1'b0;
            r_out_cout   <= 1'b0;
            r_out_valid  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_load     <= in_load;
                        r_op       <= alu_op_t'(in_op);
                        r_operand  <= in_operand;
                        r_in_ready <= 1'b0;
                        r_state    <= EXEC;
                    end
                end
                EXEC: begin
                    r_acc        <= w_new_acc;
                    r_out_result <= w_new_acc;
                    r_out_zero   <= (w_new_acc == '0);
                    r_out_cout   <= r_load ? 1'b0 : w_alu_cout;
                    r_out_valid  <= 1'b1;
                    r_state      <= RESP;
                end
                RESP: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        r_in_ready  <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= IDLE;
                end
            endcase
        end
    end

    assign in_ready   = r_in_ready;
    assign out_valid  = r_out_valid;
    assign out_result = r_out_result;
    assign out_zero   = r_out_zero;
    assign out_cout   = r_out_cout;

endmodule
